// File: rtl/pe_output_writer.sv
// rtl/pe_output_writer.sv - write-back stage: FIFO-buffered PE result stream to output memory
module pe_output_writer #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 10,
  parameter int CountWidth    = 16,
  parameter int FifoDepth     = 4,
  parameter int FifoAddrWidth = 2
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  Start,
  input  logic [AddrWidth-1:0]  BaseAddr,
  input  logic [CountWidth-1:0] OutCount,
  output logic                  Busy,
  output logic                  Done,
  input  logic                  DataInValid,
  output logic                  DataInRdy,
  input  logic [DataWidth-1:0]  DataIn,
  output logic                  MemWrEn,
  input  logic                  MemWrRdy,
  output logic [AddrWidth-1:0]  MemWrAddr,
  output logic [DataWidth-1:0]  MemWrData
);

  localparam int PtrWidth = FifoAddrWidth + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  base_q, base_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] acc_cnt_q, acc_cnt_d;
  logic [CountWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [DataWidth-1:0]  fifo_mem_q [FifoDepth];

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  last_write;
  logic [CountWidth-1:0] wr_cnt_inc;
  logic [CountWidth-1:0] acc_cnt_inc;
  logic [AddrWidth-1:0]  addr_sum;
  logic [DataWidth-1:0]  fifo_head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FifoAddrWidth] != rptr_q[FifoAddrWidth]) &&
                      (wptr_q[FifoAddrWidth-1:0] == rptr_q[FifoAddrWidth-1:0]);

  assign Busy = (state_q == StRun);
  assign Done = (state_q == StDone);

  // Once the tile's quota is accepted, surplus words are left at the producer.
  assign DataInRdy = Busy && !fifo_full && (acc_cnt_q != count_q);
  assign MemWrEn   = Busy && !fifo_empty;

  assign push = DataInValid && DataInRdy;
  assign pop  = MemWrEn && MemWrRdy;

  assign acc_cnt_inc = acc_cnt_q + CountWidth'(1);
  assign wr_cnt_inc  = wr_cnt_q + CountWidth'(1);
  assign last_write  = pop && (wr_cnt_inc == count_q);

  // Address wraps modulo 2^AddrWidth.
  assign addr_sum  = base_q + AddrWidth'(wr_cnt_q);
  assign fifo_head = fifo_mem_q[rptr_q[FifoAddrWidth-1:0]];

  assign MemWrAddr = addr_sum;
  // Stale FIFO contents are never visible: data reads 0 whenever no write is offered.
  assign MemWrData = MemWrEn ? fifo_head : '0;

  // Next-state logic for the tile FSM, counters and FIFO pointers.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;

    if (push) begin
      wptr_d    = wptr_q + PtrWidth'(1);
      acc_cnt_d = acc_cnt_inc;
    end
    if (pop) begin
      rptr_d   = rptr_q + PtrWidth'(1);
      wr_cnt_d = wr_cnt_inc;
    end

    case (state_q)
      StIdle: begin
        if (Start) begin
          base_d    = BaseAddr;
          count_d   = OutCount;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          wptr_d    = '0;
          rptr_d    = '0;
          state_d   = (OutCount == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_write) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state register; aclr discards everything including buffered words.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= StIdle;
      base_q    <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wptr_q[FifoAddrWidth-1:0]] <= DataIn;
    end
  end

endmodule

// File: tb/tb_pe_output_writer.sv
// tb/tb_pe_output_writer.sv - randomized self-checking bench for pe_output_writer
module tb_pe_output_writer;

  logic        clk = 1'b0;
  logic        aclr;
  logic        Start;
  logic [9:0]  BaseAddr;
  logic [15:0] OutCount;
  logic        Busy;
  logic        Done;
  logic        DataInValid;
  logic        DataInRdy;
  logic [31:0] DataIn;
  logic        MemWrEn;
  logic        MemWrRdy;
  logic [9:0]  MemWrAddr;
  logic [31:0] MemWrData;

  int checks = 0;
  int errors = 0;

  logic [31:0] tab [4];

  pe_output_writer #(
    .DataWidth(32), .AddrWidth(10), .CountWidth(16), .FifoDepth(4), .FifoAddrWidth(2)
  ) dut (
    .clk(clk), .aclr(aclr), .Start(Start), .BaseAddr(BaseAddr), .OutCount(OutCount),
    .Busy(Busy), .Done(Done), .DataInValid(DataInValid), .DataInRdy(DataInRdy),
    .DataIn(DataIn), .MemWrEn(MemWrEn), .MemWrRdy(MemWrRdy), .MemWrAddr(MemWrAddr),
    .MemWrData(MemWrData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, Busy, 1'b0);
    chk({tag, "_done"}, Done, 1'b0);
    chk({tag, "_rdy"}, DataInRdy, 1'b0);
    chk({tag, "_wren"}, MemWrEn, 1'b0);
    chk({tag, "_addr"}, MemWrAddr, 10'h0);
    chk({tag, "_data"}, MemWrData, 32'h0);
  endtask

  // Called just before a rising edge while the DUT is idle; returns at the
  // falling edge of the first idle cycle after the tile has completed.
  task automatic run_tile(input logic [9:0] base, input logic [15:0] cnt, input int vpct,
                          input int rpct, input int rdy_low, input bit use_tab,
                          input bit start_mid);
    logic [31:0] q[$];
    logic [31:0] pending;
    logic [31:0] p_data;
    logic [9:0]  p_addr;
    logic [9:0]  ea;
    logic        stall;
    logic        in_hs;
    logic        wr_hs;
    int          acc;
    int          wr;
    int          occ;
    acc   = 0;
    wr    = 0;
    stall = 1'b0;
    p_addr = '0;
    p_data = '0;
    pending = use_tab ? tab[0] : $urandom;

    Start = 1'b1; BaseAddr = base; OutCount = cnt;
    DataInValid = 1'b0; MemWrRdy = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; BaseAddr = 10'($urandom); OutCount = 16'($urandom);

    if (cnt == 0) begin
      DataInValid = 1'b1; DataIn = pending; MemWrRdy = 1'b1;
      @(negedge clk);
      chk("zero_done", Done, 1'b1);
      chk("zero_busy", Busy, 1'b0);
      chk("zero_wren", MemWrEn, 1'b0);
      chk("zero_rdy", DataInRdy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_idle_done", Done, 1'b0);
      chk("zero_idle_wren", MemWrEn, 1'b0);
      DataInValid = 1'b0;
      return;
    end

    for (int cyc = 0; cyc < 500; cyc++) begin
      MemWrRdy    = (cyc < rdy_low) ? 1'b0 : ($urandom_range(99) < rpct);
      DataInValid = (vpct >= 100) ? 1'b1 : ($urandom_range(99) < vpct);
      DataIn      = pending;
      Start       = start_mid ? 1'($urandom) : 1'b0;
      BaseAddr    = 10'($urandom);
      OutCount    = 16'($urandom);
      @(negedge clk);
      occ = acc - wr;
      chk("run_busy", Busy, 1'b1);
      chk("run_done", Done, 1'b0);
      chk("run_rdy", DataInRdy, (occ < 4) && (acc < int'(cnt)));
      chk("run_wren", MemWrEn, occ > 0);
      if (stall) begin
        chk("hold_en", MemWrEn, 1'b1);
        chk("hold_addr", MemWrAddr, p_addr);
        chk("hold_data", MemWrData, p_data);
      end
      if (occ > 0) begin
        ea = base + 10'(wr);
        chk("wr_addr", MemWrAddr, ea);
        chk("wr_data", MemWrData, q[0]);
      end
      stall  = MemWrEn && !MemWrRdy;
      p_addr = MemWrAddr;
      p_data = MemWrData;
      in_hs  = DataInValid && DataInRdy;
      wr_hs  = MemWrEn && MemWrRdy;
      if (wr_hs && q.size() > 0) begin
        void'(q.pop_front());
        wr++;
      end
      if (in_hs) begin
        q.push_back(DataIn);
        acc++;
        pending = (use_tab && acc < 4) ? tab[acc] : $urandom;
      end
      @(posedge clk); #1;
      if (wr >= int'(cnt)) break;
    end

    chk("tile_writes", 32'(wr), 32'(cnt));
    chk("tile_accepts", 32'(acc), 32'(cnt));
    Start = 1'b0; MemWrRdy = 1'b1; DataIn = pending;
    @(negedge clk);
    chk("fin_done", Done, 1'b1);
    chk("fin_busy", Busy, 1'b0);
    chk("fin_wren", MemWrEn, 1'b0);
    chk("fin_rdy", DataInRdy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_done", Done, 1'b0);
    chk("idle_busy", Busy, 1'b0);
    chk("idle_rdy", DataInRdy, 1'b0);
    DataInValid = 1'b0;
  endtask

  initial begin
    aclr = 1'b1; Start = 1'b0; BaseAddr = '0; OutCount = '0;
    DataInValid = 1'b0; DataIn = '0; MemWrRdy = 1'b0;
    tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33; tab[3] = 32'h44;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    aclr = 1'b0;

    // basic tile
    run_tile(10'h010, 16'd4, 100, 100, 0, 1'b1, 1'b0);
    // backpressure: memory stalled for 10 cycles
    run_tile(10'($urandom), 16'd8, 100, 100, 10, 1'b0, 1'b0);
    // address wrap
    run_tile(10'h3FE, 16'd4, 100, 100, 0, 1'b0, 1'b0);
    // over-supply then zero count
    run_tile(10'($urandom), 16'd2, 100, 100, 0, 1'b0, 1'b0);
    run_tile(10'($urandom), 16'd0, 100, 100, 0, 1'b0, 1'b0);
    // Start pulsed during RUN
    run_tile(10'h155, 16'd6, 70, 60, 0, 1'b0, 1'b1);
    // random tiles
    for (int t = 0; t < 6; t++) begin
      run_tile(10'($urandom), 16'($urandom_range(1, 12)), $urandom_range(30, 100),
               $urandom_range(30, 100), $urandom_range(0, 6), 1'b0, 1'($urandom));
    end

    // reset mid-tile with two words buffered
    Start = 1'b1; BaseAddr = 10'h100; OutCount = 16'd8; MemWrRdy = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; DataInValid = 1'b1; DataIn = 32'hAAAA_0001;
    @(posedge clk); #1;
    DataIn = 32'hAAAA_0002;
    @(posedge clk); #1;
    DataInValid = 1'b0;
    chk("pre_rst_wren", MemWrEn, 1'b1);
    chk("pre_rst_data", MemWrData, 32'hAAAA_0001);
    chk("pre_rst_addr", MemWrAddr, 10'h100);
    aclr = 1'b1;
    #1;
    chk_quiet("mid_rst");
    @(negedge clk);
    aclr = 1'b0;
    chk_quiet("post_rst");
    run_tile(10'h2A0, 16'd3, 100, 100, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
